// File: rtl/tlc_pkg.sv
// Shared definitions for the junction safety monitor: lamp codes, head indices,
// fault causes and monitor states.
package tlc_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  localparam int HD_M1     = 0;
  localparam int HD_M2     = 1;
  localparam int HD_MT     = 2;
  localparam int HD_S      = 3;
  localparam int NUM_HEADS = 4;

  typedef enum logic [2:0] {
    FC_NONE      = 3'd0,
    FC_INVALID   = 3'd1,
    FC_CONFLICT  = 3'd2,
    FC_TRANS     = 3'd3,
    FC_SHORT_YEL = 3'd4
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_NORMAL  = 2'd1,
    ST_FLASH   = 2'd2
  } mon_state_e;

  function automatic logic code_valid(input logic [2:0] c);
    return (c == LT_RED) || (c == LT_YEL) || (c == LT_GRN);
  endfunction

  function automatic logic code_active(input logic [2:0] c);
    return code_valid(c) && (c != LT_RED);
  endfunction

endpackage

// File: rtl/tlc_head_checker.sv
// Per-head legality checker: tracks the last valid code and yellow dwell, and
// flags illegal transitions and short yellows while enabled.
module tlc_head_checker
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] code,
  output logic       valid,
  output logic       trans_bad,
  output logic       yel_bad
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam logic [YW-1:0] YEL_SAT = YW'(MIN_YELLOW);

  logic [2:0]    prev_q, prev_d;
  logic [YW-1:0] yel_cnt_q, yel_cnt_d;
  logic          legal;

  // Invalid samples are neither captured nor checked; the filter in the top
  // owns them, so a one-cycle glitch cannot fake a transition afterwards.
  always_comb begin
    valid     = code_valid(code);
    prev_d    = valid ? code : prev_q;
    yel_cnt_d = yel_cnt_q;
    if (code == LT_YEL) begin
      if (yel_cnt_q != YEL_SAT) yel_cnt_d = yel_cnt_q + 1'b1;
    end else if (valid) begin
      yel_cnt_d = '0;
    end
    legal = (code == prev_q) ||
            ((prev_q == LT_RED) && (code == LT_GRN)) ||
            ((prev_q == LT_GRN) && (code == LT_YEL)) ||
            ((prev_q == LT_YEL) && (code == LT_RED));
    trans_bad = en && valid && !legal;
    yel_bad   = en && valid && (prev_q == LT_YEL) && (code == LT_RED) &&
                (yel_cnt_q < YEL_SAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= LT_RED;
      yel_cnt_q <= '0;
    end else begin
      prev_q    <= prev_d;
      yel_cnt_q <= yel_cnt_d;
    end
  end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Safety stage between the light sequencer and the lamp drivers: forwards head
// codes one cycle late, and latches all-red flash on any detected fault.
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW     = 3,
  parameter int FILTER_CYCLES  = 2,
  parameter int FLASH_HALF     = 4,
  parameter int STARTUP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_M1,
  input  logic [2:0] in_M2,
  input  logic [2:0] in_MT,
  input  logic [2:0] in_S,
  input  logic       clr_req,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] fault_head,
  output logic       clr_ack
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int LW = $clog2(2 * FLASH_HALF);
  localparam logic [FW-1:0] FILT_MAX   = FW'(FILTER_CYCLES);
  localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYCLES - 1);
  localparam logic [LW-1:0] FLASH_LAST = LW'(2 * FLASH_HALF - 1);
  localparam logic [LW-1:0] FLASH_ON   = LW'(FLASH_HALF);

  logic [NUM_HEADS-1:0][2:0] in_code;
  logic [NUM_HEADS-1:0]      head_valid, trans_bad, yel_bad;
  logic [NUM_HEADS-1:0]      act, inv_heads, conf_heads, cause_heads;
  logic                      chk_en, any_inv, any_conf, bad, filt_fire;
  logic                      s_conf, mt_conf;
  fault_code_e               cause;

  mon_state_e                state_q, state_d;
  logic [SW-1:0]             start_cnt_q, start_cnt_d;
  logic [FW-1:0]             filt_cnt_q, filt_cnt_d, filt_inc;
  logic [LW-1:0]             flash_cnt_q, flash_cnt_d;
  logic [NUM_HEADS-1:0][2:0] lamp_q, lamp_d;
  logic                      fault_q, fault_d;
  fault_code_e               fault_code_q, fault_code_d;
  logic [NUM_HEADS-1:0]      fault_head_q, fault_head_d;
  logic                      clr_ack_q, clr_ack_d;

  assign in_code[HD_M1] = in_M1;
  assign in_code[HD_M2] = in_M2;
  assign in_code[HD_MT] = in_MT;
  assign in_code[HD_S]  = in_S;
  assign chk_en         = (state_q != ST_STARTUP);

  for (genvar g = 0; g < NUM_HEADS; g++) begin : g_head
    tlc_head_checker #(.MIN_YELLOW(MIN_YELLOW)) u_chk (
      .clk       (clk),
      .rst       (rst),
      .en        (chk_en),
      .code      (in_code[g]),
      .valid     (head_valid[g]),
      .trans_bad (trans_bad[g]),
      .yel_bad   (yel_bad[g])
    );
  end

  // Conflict matrix and highest-priority cause for this cycle.
  always_comb begin
    for (int i = 0; i < NUM_HEADS; i++) act[i] = code_active(in_code[i]);
    s_conf     = act[HD_S] && (act[HD_M1] || act[HD_M2] || act[HD_MT]);
    mt_conf    = act[HD_MT] && act[HD_M2];
    conf_heads = (s_conf ? act : '0) |
                 (mt_conf ? ((NUM_HEADS)'(1) << HD_MT) | ((NUM_HEADS)'(1) << HD_M2) : '0);
    inv_heads  = ~head_valid;
    any_inv    = |inv_heads;
    any_conf   = |conf_heads;
    bad        = any_inv || any_conf;
    filt_inc   = filt_cnt_q + 1'b1;
    filt_fire  = bad && (filt_inc >= FILT_MAX);
    cause       = FC_NONE;
    cause_heads = '0;
    if (filt_fire && any_inv) begin
      cause       = FC_INVALID;
      cause_heads = inv_heads;
    end else if (filt_fire && any_conf) begin
      cause       = FC_CONFLICT;
      cause_heads = conf_heads;
    end else if (|trans_bad) begin
      cause       = FC_TRANS;
      cause_heads = trans_bad;
    end else if (|yel_bad) begin
      cause       = FC_SHORT_YEL;
      cause_heads = yel_bad;
    end
  end

  // Clear handshake: clr_req is a level held by the requester; clr_ack is a
  // one-cycle pulse on the edge the clear is taken. A request that arrives
  // outside FLASH, or while any fault condition is present, is dropped silently
  // and must be re-asserted.
  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    filt_cnt_d   = '0;
    flash_cnt_d  = flash_cnt_q;
    lamp_d       = lamp_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    fault_head_d = fault_head_q;
    clr_ack_d    = 1'b0;
    unique case (state_q)
      ST_STARTUP: begin
        lamp_d = {NUM_HEADS{LT_RED}};
        if (start_cnt_q == START_LAST) begin
          state_d     = ST_NORMAL;
          start_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      ST_NORMAL: begin
        if (bad) filt_cnt_d = filt_inc;
        if (cause != FC_NONE) begin
          fault_d      = 1'b1;
          fault_code_d = cause;
          fault_head_d = cause_heads;
          state_d      = ST_FLASH;
          flash_cnt_d  = '0;
          lamp_d       = {NUM_HEADS{LT_RED}};
        end else if (!bad) begin
          lamp_d = in_code;
        end
      end
      ST_FLASH: begin
        flash_cnt_d = (flash_cnt_q == FLASH_LAST) ? '0 : flash_cnt_q + 1'b1;
        lamp_d      = (flash_cnt_d < FLASH_ON) ? {NUM_HEADS{LT_RED}} : {NUM_HEADS{LT_OFF}};
        if (clr_req && !bad && (cause == FC_NONE)) begin
          clr_ack_d    = 1'b1;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          fault_head_d = '0;
          state_d      = ST_STARTUP;
          start_cnt_d  = '0;
          lamp_d       = {NUM_HEADS{LT_RED}};
        end
      end
      default: begin
        state_d = ST_STARTUP;
        lamp_d  = {NUM_HEADS{LT_RED}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_STARTUP;
      start_cnt_q  <= '0;
      filt_cnt_q   <= '0;
      flash_cnt_q  <= '0;
      lamp_q       <= {NUM_HEADS{LT_RED}};
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      fault_head_q <= '0;
      clr_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      filt_cnt_q   <= filt_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      lamp_q       <= lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      fault_head_q <= fault_head_d;
      clr_ack_q    <= clr_ack_d;
    end
  end

  assign lamp_M1    = lamp_q[HD_M1];
  assign lamp_M2    = lamp_q[HD_M2];
  assign lamp_MT    = lamp_q[HD_MT];
  assign lamp_S     = lamp_q[HD_S];
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_head = fault_head_q;
  assign clr_ack    = clr_ack_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed bench for the junction safety monitor: a vector table walked one
// clock per row, then hand-written asynchronous reset and priority sequences.
module tb_tlc_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] X = 3'b011;
  localparam logic [2:0] O = 3'b000;

  typedef struct {
    logic [2:0]  m1, m2, mt, s;
    logic        clr;
    logic [20:0] exp;
  } vec_t;

  logic       clk, rst;
  logic [2:0] in_M1, in_M2, in_MT, in_S;
  logic       clr_req;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_head;
  logic       clr_ack;

  vec_t vecs[$];
  int   vec_cnt;
  int   miscompares;

  tlc_conflict_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .in_M1      (in_M1),
    .in_M2      (in_M2),
    .in_MT      (in_MT),
    .in_S       (in_S),
    .clr_req    (clr_req),
    .lamp_M1    (lamp_M1),
    .lamp_M2    (lamp_M2),
    .lamp_MT    (lamp_MT),
    .lamp_S     (lamp_S),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_head (fault_head),
    .clr_ack    (clr_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected-output record: lamps M1,M2,MT,S, fault, code, head {S,MT,M2,M1}, ack
  function automatic logic [20:0] ex(input logic [2:0] l1, l2, lt, ls, input logic f,
                                     input logic [2:0] c, input logic [3:0] h, input logic a);
    return {l1, l2, lt, ls, f, c, h, a};
  endfunction

  function automatic logic [20:0] ok(input logic [2:0] l1, l2, lt, ls);
    return {l1, l2, lt, ls, 1'b0, 3'd0, 4'd0, 1'b0};
  endfunction

  task automatic add(input logic [2:0] m1, m2, mt, s, input logic clr, input logic [20:0] e);
    vec_t v;
    v.m1 = m1; v.m2 = m2; v.mt = mt; v.s = s; v.clr = clr; v.exp = e;
    vecs.push_back(v);
  endtask

  // driver: present inputs, then sample outputs 1 time unit after the edge
  task automatic apply(input logic [2:0] m1, m2, mt, s, input logic clr);
    in_M1 = m1; in_M2 = m2; in_MT = mt; in_S = s; clr_req = clr;
    @(posedge clk);
    #1;
  endtask

  // scoreboard comparison
  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] got;
    got = {lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code, fault_head, clr_ack};
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got lamps=%b_%b_%b_%b fault=%b code=%0d head=%b ack=%b, exp lamps=%b_%b_%b_%b fault=%b code=%0d head=%b ack=%b",
               name, got[20:18], got[17:15], got[14:12], got[11:9], got[8], got[7:5], got[4:1], got[0],
               exp[20:18], exp[17:15], exp[14:12], exp[11:9], exp[8], exp[7:5], exp[4:1], exp[0]);
    end
  endtask

  initial begin
    logic [20:0] rst_exp;
    vec_cnt     = 0;
    miscompares = 0;
    rst_exp     = ok(R, R, R, R);

    // startup: four all-red cycles, inputs ignored even when green
    for (int i = 0; i < 3; i++) add(R, R, R, R, 0, ok(R, R, R, R));
    add(G, G, R, R, 0, ok(R, R, R, R));
    // legal six-phase cycle, pass-through with one cycle latency
    add(G, G, R, R, 0, ok(G, G, R, R));
    for (int i = 0; i < 3; i++) add(G, Y, R, R, 0, ok(G, Y, R, R));
    add(G, R, G, R, 0, ok(G, R, G, R));
    for (int i = 0; i < 3; i++) add(Y, R, Y, R, 0, ok(Y, R, Y, R));
    add(R, R, R, R, 0, ok(R, R, R, R));
    add(R, R, R, G, 0, ok(R, R, R, G));
    for (int i = 0; i < 3; i++) add(R, R, R, Y, 0, ok(R, R, R, Y));
    add(R, R, R, R, 0, ok(R, R, R, R));
    // one-cycle invalid glitch on MT: hold, then resume
    add(R, R, G, R, 0, ok(R, R, G, R));
    add(R, R, X, R, 0, ok(R, R, G, R));
    for (int i = 0; i < 3; i++) add(R, R, Y, R, 0, ok(R, R, Y, R));
    add(R, R, R, R, 0, ok(R, R, R, R));
    // S with M1 green: hold one cycle, conflict fault on the second
    add(G, R, R, G, 0, ok(R, R, R, R));
    add(G, R, R, G, 0, ex(R, R, R, R, 1, 3'd2, 4'b1001, 0));
    // flash: clear refused while conflict persists, 4 on / 4 off phases
    add(G, R, R, G, 1, ex(R, R, R, R, 1, 3'd2, 4'b1001, 0));
    for (int i = 0; i < 2; i++) add(R, R, R, R, 0, ex(R, R, R, R, 1, 3'd2, 4'b1001, 0));
    for (int i = 0; i < 4; i++) add(R, R, R, R, 0, ex(O, O, O, O, 1, 3'd2, 4'b1001, 0));
    for (int i = 0; i < 2; i++) add(R, R, R, R, 0, ex(R, R, R, R, 1, 3'd2, 4'b1001, 0));
    // accepted clear, then startup (clr there is ignored), then NORMAL
    add(R, R, R, R, 1, ex(R, R, R, R, 0, 3'd0, 4'b0000, 1));
    add(R, R, R, R, 0, ok(R, R, R, R));
    add(R, R, R, R, 1, ok(R, R, R, R));
    add(R, R, R, R, 0, ok(R, R, R, R));
    add(G, G, R, R, 0, ok(R, R, R, R));
    add(G, G, R, R, 0, ok(G, G, R, R));
    // M2 green straight to red: immediate transition fault
    add(G, R, R, R, 0, ex(R, R, R, R, 1, 3'd3, 4'b0010, 0));
    add(G, R, R, R, 1, ex(R, R, R, R, 0, 3'd0, 4'b0000, 1));
    for (int i = 0; i < 4; i++) add(G, R, R, R, 0, ok(R, R, R, R));
    add(G, R, R, R, 1, ok(G, R, R, R));
    // yellow held only two cycles: short-yellow fault
    for (int i = 0; i < 2; i++) add(Y, R, R, R, 0, ok(Y, R, R, R));
    add(R, R, R, R, 0, ex(R, R, R, R, 1, 3'd4, 4'b0001, 0));
    // clear with a simultaneous illegal R->Y: refused, first cause kept
    add(Y, R, R, R, 1, ex(R, R, R, R, 1, 3'd4, 4'b0001, 0));
    add(R, R, R, R, 0, ex(R, R, R, R, 1, 3'd4, 4'b0001, 0));

    // reset applied asynchronously, released just after an edge
    rst = 1'b1; in_M1 = R; in_M2 = R; in_MT = R; in_S = R; clr_req = 1'b0;
    #2;
    check("reset_initial", rst_exp);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].m1, vecs[i].m2, vecs[i].mt, vecs[i].s, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // asynchronous reset mid-flash
    #2 rst = 1'b1;
    #1 check("rst_async_flash", rst_exp);
    @(posedge clk);
    #1 check("rst_held_edge", rst_exp);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(R, R, R, R, 0);
      check("restart_red", rst_exp);
    end
    apply(G, R, R, R, 0);
    check("restart_pass", ok(G, R, R, R));
    apply(G, R, R, G, 0);
    check("filter_hold", ok(G, R, R, R));

    // asynchronous reset mid-filter
    #2 rst = 1'b1;
    #1 check("rst_async_filter", rst_exp);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(R, R, R, R, 0);
      check("restart2_red", rst_exp);
    end
    apply(G, R, R, R, 0);
    check("restart2_pass", ok(G, R, R, R));

    // invalid and conflict together: invalid wins priority
    apply(G, R, X, G, 0);
    check("prio_hold", ok(G, R, R, R));
    apply(G, R, X, G, 0);
    check("prio_invalid", ex(R, R, R, R, 1, 3'd1, 4'b0100, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
